// File: rtl/victim_buffer_mq_pkg.sv
// rtl/victim_buffer_mq_pkg.sv - shared address/byte types and label helpers for the victim buffer
`ifndef VB_LINE_LABEL
`define VB_LINE_LABEL(line, data_w, label_w) line[(data_w) +: (label_w)]
`endif

package victim_buffer_mq_pkg;
  localparam int PHYS_WIDTH = 40;

  typedef logic [PHYS_WIDTH-1:0] phys_t;
  typedef logic [7:0]            uint8_t;

  // Label bits left once the byte offset within a line is stripped from a physical address.
  function automatic int label_width(input int line_width);
    return $bits(phys_t) - $clog2(line_width / 8);
  endfunction
endpackage

// File: rtl/victim_buffer_match.sv
// rtl/victim_buffer_match.sv - one-hot label match across all buffered entries
module victim_buffer_match #(
  parameter int LINE_DEPTH  = 8,
  parameter int LABEL_WIDTH = 35,
  parameter int PTR_W       = 3
) (
  input  logic [LINE_DEPTH-1:0]                  valid,
  input  logic [LINE_DEPTH-1:0][LABEL_WIDTH-1:0] labels,
  input  logic [LABEL_WIDTH-1:0]                 probe,
  input  logic                                   excl_en,
  input  logic [PTR_W-1:0]                       excl_idx,
  output logic [LINE_DEPTH-1:0]                  hit,
  output logic [LINE_DEPTH-1:0]                  hit_excl
);
  // Compare the probe against every valid label; hit_excl drops the entry leaving this cycle.
  always_comb begin
    hit      = '0;
    hit_excl = '0;
    for (int i = 0; i < LINE_DEPTH; i++) begin
      hit[i]      = valid[i] && (labels[i] == probe);
      hit_excl[i] = hit[i] && !(excl_en && (excl_idx == PTR_W'(i)));
    end
  end
endmodule

// File: rtl/victim_buffer_mq.sv
// rtl/victim_buffer_mq.sv - coalescing FIFO victim buffer with multiple lookup/byte-write ports
module victim_buffer_mq
  import victim_buffer_mq_pkg::*;
#(
  parameter int LINE_WIDTH      = 256,
  parameter int LINE_DEPTH      = 8,
  parameter int N_QUERY         = 2,
  parameter int DRAIN_THRESHOLD = 6,
  localparam int LABEL_WIDTH    = label_width(LINE_WIDTH),
  localparam int BE_WIDTH       = LINE_WIDTH / 8,
  localparam int LINE_W         = LABEL_WIDTH + LINE_WIDTH,
  localparam int OCC_W          = (LINE_DEPTH == 0) ? 1 : $clog2(LINE_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [LINE_W-1:0]                   pline,
  input  logic                                push,
  output logic                                pushed,
  output logic                                coalesced,
  output logic [LINE_W-1:0]                   rline,
  input  logic                                pop,
  output logic                                full,
  output logic                                empty,
  output logic [OCC_W-1:0]                    occupancy,
  output logic                                drain_req,
  input  logic [N_QUERY-1:0][LABEL_WIDTH-1:0] query_label,
  output logic [N_QUERY-1:0]                  query_found,
  output logic [N_QUERY-1:0][LINE_WIDTH-1:0]  query_rdata,
  input  logic [N_QUERY-1:0][LINE_WIDTH-1:0]  query_wdata,
  input  logic [N_QUERY-1:0][BE_WIDTH-1:0]    query_wbe,
  input  logic [N_QUERY-1:0]                  write,
  output logic [N_QUERY-1:0]                  written
);
  if (LINE_DEPTH == 0) begin : g_fall
    // No storage: the push side is wired straight through to the pop side.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, query_label, query_wdata, query_wbe, write};
    assign rline       = pline;
    assign empty       = !push;
    assign full        = !pop;
    assign pushed      = push && pop;
    assign coalesced   = 1'b0;
    assign query_found = '0;
    assign query_rdata = '0;
    assign written     = '0;
    assign occupancy   = '0;
    assign drain_req   = push;
  end else begin : g_buf
    localparam int PTR_W = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;

    logic [LINE_DEPTH-1:0]                  valid_q, valid_d;
    logic [LINE_DEPTH-1:0][LABEL_WIDTH-1:0] label_q, label_d;
    logic [LINE_DEPTH-1:0][LINE_WIDTH-1:0]  data_q, data_d;
    logic [PTR_W-1:0]                       head_q, tail_q;
    logic [OCC_W-1:0]                       occ_q;
    logic                                   pop_ok, coal, alloc;
    logic [LINE_DEPTH-1:0]                  c_hit, unused_c_hit_raw;
    logic [N_QUERY-1:0][LINE_DEPTH-1:0]     q_hit, q_hit_excl;
    logic [LABEL_WIDTH-1:0]                 p_label;
    logic [LINE_WIDTH-1:0]                  p_data;

    assign p_label   = `VB_LINE_LABEL(pline, LINE_WIDTH, LABEL_WIDTH);
    assign p_data    = pline[LINE_WIDTH-1:0];
    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_W'(LINE_DEPTH));
    assign occupancy = occ_q;
    assign drain_req = (occ_q >= OCC_W'(DRAIN_THRESHOLD));
    assign rline     = {label_q[head_q], data_q[head_q]};
    assign pop_ok    = pop && !empty;
    // The popped head never absorbs a push, so a matching push goes to a fresh slot.
    assign coal      = push && (|c_hit);
    assign alloc     = push && !coal && (!full || pop_ok);
    assign pushed    = coal || alloc;
    assign coalesced = coal;

    victim_buffer_match #(.LINE_DEPTH(LINE_DEPTH), .LABEL_WIDTH(LABEL_WIDTH), .PTR_W(PTR_W)) u_coal_match (
      .valid(valid_q), .labels(label_q), .probe(p_label),
      .excl_en(pop_ok), .excl_idx(head_q), .hit(unused_c_hit_raw), .hit_excl(c_hit)
    );

    for (genvar p = 0; p < N_QUERY; p++) begin : g_query
      victim_buffer_match #(.LINE_DEPTH(LINE_DEPTH), .LABEL_WIDTH(LABEL_WIDTH), .PTR_W(PTR_W)) u_match (
        .valid(valid_q), .labels(label_q), .probe(query_label[p]),
        .excl_en(pop_ok), .excl_idx(head_q), .hit(q_hit[p]), .hit_excl(q_hit_excl[p])
      );
    end

    // Per-port lookup result and write acknowledge, all from pre-update state.
    always_comb begin
      query_found = '0;
      query_rdata = '0;
      written     = '0;
      for (int p = 0; p < N_QUERY; p++) begin
        query_found[p] = |q_hit[p];
        written[p]     = write[p] && (|q_hit_excl[p]);
        for (int i = 0; i < LINE_DEPTH; i++)
          if (q_hit[p][i]) query_rdata[p] = query_rdata[p] | data_q[i];
      end
    end

    // Next entry state: pop, coalesce, byte writes (lower port applied last so it wins), then allocate.
    always_comb begin
      valid_d = valid_q;
      label_d = label_q;
      data_d  = data_q;
      if (pop_ok) valid_d[head_q] = 1'b0;
      for (int i = 0; i < LINE_DEPTH; i++) begin
        if (coal && c_hit[i]) data_d[i] = p_data;
        for (int p = N_QUERY - 1; p >= 0; p--)
          if (write[p] && q_hit_excl[p][i])
            for (int b = 0; b < BE_WIDTH; b++)
              if (query_wbe[p][b]) data_d[i][8*b +: 8] = query_wdata[p][8*b +: 8];
      end
      if (alloc) begin
        valid_d[tail_q] = 1'b1;
        label_d[tail_q] = p_label;
        data_d[tail_q]  = p_data;
      end
    end

    // Register entries and pointers; reset drops everything without write-back.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        label_q <= '0;
        data_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        occ_q   <= '0;
      end else begin
        valid_q <= valid_d;
        label_q <= label_d;
        data_q  <= data_d;
        head_q  <= head_q + PTR_W'(pop_ok);
        tail_q  <= tail_q + PTR_W'(alloc);
        occ_q   <= occ_q + OCC_W'(alloc) - OCC_W'(pop_ok);
      end
    end
  end
endmodule

// File: tb/tb_victim_buffer_mq.sv
// tb/tb_victim_buffer_mq.sv - directed self-checking bench for victim_buffer_mq
module tb_victim_buffer_mq;
  import victim_buffer_mq_pkg::*;

  localparam int LW   = 256;
  localparam int LBW  = label_width(LW);
  localparam int BEW  = LW / 8;
  localparam int LNW  = LBW + LW;
  localparam int NQ   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LNW-1:0]          pline;
  logic                    push, pushed, coalesced, pop, full, empty, drain_req;
  logic [LNW-1:0]          rline;
  logic [3:0]              occupancy;
  logic [NQ-1:0][LBW-1:0]  query_label;
  logic [NQ-1:0]           query_found, write, written;
  logic [NQ-1:0][LW-1:0]   query_rdata, query_wdata;
  logic [NQ-1:0][BEW-1:0]  query_wbe;

  int total = 0;
  int passed = 0;
  int failed = 0;
  logic [LW-1:0] exp_13;

  victim_buffer_mq #(.LINE_WIDTH(LW), .LINE_DEPTH(8), .N_QUERY(NQ), .DRAIN_THRESHOLD(6)) dut (
    .clk(clk), .rst(rst), .pline(pline), .push(push), .pushed(pushed), .coalesced(coalesced),
    .rline(rline), .pop(pop), .full(full), .empty(empty), .occupancy(occupancy),
    .drain_req(drain_req), .query_label(query_label), .query_found(query_found),
    .query_rdata(query_rdata), .query_wdata(query_wdata), .query_wbe(query_wbe),
    .write(write), .written(written)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] dat(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [LNW-1:0] mk(input logic [7:0] label, input logic [LW-1:0] d);
    return {LBW'(label), d};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    rst = 1'b1; pline = '0; push = 1'b0; pop = 1'b0;
    query_label = '0; query_wdata = '0; query_wbe = '0; write = '0;
    query_label[0] = LBW'(8'h10);
    exp_13 = {{24{8'h13}}, {4{8'h22}}, {4{8'h11}}};
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_empty", 512'(empty), 512'(1));
    check("rst_full", 512'(full), 512'(0));
    check("rst_occ", 512'(occupancy), 512'(0));
    check("rst_drain", 512'(drain_req), 512'(0));
    check("rst_pushed", 512'(pushed), 512'(0));
    check("rst_found", 512'(query_found), 512'(0));
    tick();

    for (int i = 0; i < 8; i++) begin
      pline = mk(8'(8'h10 + i), dat(8'(8'h10 + i)));
      push = 1'b1;
      settle();
      check("fill_pushed", 512'(pushed), 512'(1));
      check("fill_occ", 512'(occupancy), 512'(i));
      check("fill_drain", 512'(drain_req), 512'(i >= 6));
      tick();
    end
    push = 1'b0;
    settle();
    check("full_flag", 512'(full), 512'(1));
    check("full_occ", 512'(occupancy), 512'(8));
    check("full_drain", 512'(drain_req), 512'(1));
    check("full_head", 512'(rline), 512'(mk(8'h10, dat(8'h10))));
    tick();

    pline = mk(8'h18, dat(8'h18)); push = 1'b1;
    settle();
    check("push_full_rejected", 512'(pushed), 512'(0));
    tick();
    pline = mk(8'h20, dat(8'h20)); pop = 1'b1;
    settle();
    check("push_pop_pushed", 512'(pushed), 512'(1));
    check("push_pop_coal", 512'(coalesced), 512'(0));
    tick();
    push = 1'b0; pop = 1'b0;
    settle();
    check("push_pop_head", 512'(rline), 512'(mk(8'h11, dat(8'h11))));
    check("push_pop_occ", 512'(occupancy), 512'(8));
    tick();

    pline = mk(8'h12, dat(8'hAA)); push = 1'b1;
    settle();
    check("coal_pushed", 512'(pushed), 512'(1));
    check("coal_flag", 512'(coalesced), 512'(1));
    tick();
    push = 1'b0;
    query_label[0] = LBW'(8'h12); query_label[1] = LBW'(8'h13);
    settle();
    check("coal_occ", 512'(occupancy), 512'(8));
    check("coal_found", 512'(query_found), 512'(2'b11));
    check("coal_rdata", 512'(query_rdata[0]), 512'(dat(8'hAA)));
    check("coal_other", 512'(query_rdata[1]), 512'(dat(8'h13)));
    query_label[1] = LBW'(8'h77);
    #1;
    check("miss_found", 512'(query_found[1]), 512'(0));
    check("miss_rdata", 512'(query_rdata[1]), 512'(0));
    tick();

    query_label[0] = LBW'(8'h13); query_label[1] = LBW'(8'h13);
    query_wbe[0] = BEW'(32'h0000_000F); query_wdata[0] = {32{8'h11}};
    query_wbe[1] = BEW'(32'h0000_00FF); query_wdata[1] = {32{8'h22}};
    write = 2'b11;
    settle();
    check("bw_written", 512'(written), 512'(2'b11));
    tick();
    write = 2'b00;
    settle();
    check("bw_rdata", 512'(query_rdata[0]), 512'(exp_13));
    tick();

    pop = 1'b1;
    settle();
    check("pop_11", 512'(rline), 512'(mk(8'h11, dat(8'h11))));
    tick();
    settle();
    check("pop_12", 512'(rline), 512'(mk(8'h12, dat(8'hAA))));
    tick();
    settle();
    check("pop_13", 512'(rline), 512'(mk(8'h13, exp_13)));
    tick();
    pop = 1'b0;
    settle();
    check("pop_occ", 512'(occupancy), 512'(5));
    tick();

    pop = 1'b1; push = 1'b1; pline = mk(8'h14, dat(8'h99));
    query_label[0] = LBW'(8'h14); write = 2'b01;
    query_wbe[0] = '1; query_wdata[0] = dat(8'h55);
    settle();
    check("head_written", 512'(written), 512'(0));
    check("head_coal", 512'(coalesced), 512'(0));
    check("head_pushed", 512'(pushed), 512'(1));
    check("head_rline", 512'(rline), 512'(mk(8'h14, dat(8'h14))));
    tick();
    pop = 1'b0; push = 1'b0; write = 2'b00;
    settle();
    check("realloc_occ", 512'(occupancy), 512'(5));
    check("realloc_found", 512'(query_found[0]), 512'(1));
    check("realloc_rdata", 512'(query_rdata[0]), 512'(dat(8'h99)));
    check("realloc_head", 512'(rline), 512'(mk(8'h15, dat(8'h15))));
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0; query_label[0] = LBW'(8'h15);
    settle();
    check("rst2_empty", 512'(empty), 512'(1));
    check("rst2_occ", 512'(occupancy), 512'(0));
    check("rst2_found", 512'(query_found), 512'(0));
    check("rst2_drain", 512'(drain_req), 512'(0));
    tick();

    pop = 1'b1;
    tick();
    pop = 1'b0;
    settle();
    check("pop_empty_occ", 512'(occupancy), 512'(0));
    check("pop_empty_flag", 512'(empty), 512'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
